encoder83_top: RTL and testbench

Registered 8-to-3 priority encoder with enable, valid flag and 7-segment display driver. Finds the index of the highest set bit of an 8-bit input vector, flags whether any bit was set, and drives a single active-low 7-segment digit with that index. Leaf block at the board-I/O level: switches on `x`/`ena`, outputs to LEDs and one seven-segment digit.

---
 rtl/encoder83_top_if.sv | 24 ++
 rtl/encoder83_top.sv | 73 +++++++
 tb/tb_encoder83_top.sv | 137 +++++++++++++
 3 files changed

// File: rtl/encoder83_top_if.sv
// Board-side bundle for the 8-to-3 priority encoder: request/enable in, index/valid/segments out.
interface encoder83_if;
    logic [7:0] x;
    logic       ena;
    logic [2:0] y;
    logic       idx;
    logic [6:0] h;

    modport master (
        output x,
        output ena,
        input  y,
        input  idx,
        input  h
    );

    modport slave (
        input  x,
        input  ena,
        output y,
        output idx,
        output h
    );
endinterface

// File: rtl/encoder83_top.sv
// Registered 8-to-3 priority encoder with valid flag and active-low 7-segment digit.
// Define ENCODER83_SEG_EN to build the segment decoder; otherwise h is tied blank (7'h7F).
module encoder83_top (
    input  logic        clk,
    input  logic        rst_n,
    encoder83_if.slave  bus
);

    localparam logic [6:0] SegBlank = 7'h7F;

    logic [2:0] y_d, y_q;
    logic       idx_d, idx_q;

    // Ascending scan so the last hit, the highest set bit, wins.
    always_comb begin
        y_d = 3'd0;
        if (bus.ena) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.x[i]) begin
                    y_d = 3'(i);
                end
            end
        end
        idx_d = bus.ena && (bus.x != 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= 3'd0;
            idx_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            idx_q <= idx_d;
        end
    end

    assign bus.y   = y_q;
    assign bus.idx = idx_q;

`ifdef ENCODER83_SEG_EN
    logic [6:0] h_d, h_q;

    always_comb begin
        h_d = SegBlank;
        if (idx_d) begin
            case (y_d)
                3'd0:    h_d = 7'h40;
                3'd1:    h_d = 7'h79;
                3'd2:    h_d = 7'h24;
                3'd3:    h_d = 7'h30;
                3'd4:    h_d = 7'h19;
                3'd5:    h_d = 7'h12;
                3'd6:    h_d = 7'h02;
                3'd7:    h_d = 7'h78;
                default: h_d = SegBlank;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= SegBlank;
        end else begin
            h_q <= h_d;
        end
    end

    assign bus.h = h_q;
`else
    assign bus.h = SegBlank;
`endif

endmodule

// File: tb/tb_encoder83_top.sv
// Self-checking bench for encoder83_top: directed plan plus random stimulus against an
// arithmetic reference model.
module tb_encoder83_top;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    encoder83_if bus ();

    encoder83_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [8];
    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Highest set bit by repeated halving: floor(log2(v)).
    function automatic int model_y(input logic [7:0] v, input logic e);
        int n;
        int t;
        n = 0;
        t = int'(v);
        if (!e || t == 0) return 0;
        while (t > 1) begin
            t = t / 2;
            n++;
        end
        return n;
    endfunction

    function automatic logic [6:0] model_h(input logic vld, input int yy);
`ifdef ENCODER83_SEG_EN
        return vld ? seg_tab[yy] : 7'h7F;
`else
        return 7'h7F;
`endif
    endfunction

    task automatic check_out(input string tag, input int ey, input logic ei, input logic [6:0] eh);
        check({tag, ".y"},   32'(bus.y),   32'(ey));
        check({tag, ".idx"}, 32'(bus.idx), 32'(ei));
        check({tag, ".h"},   32'(bus.h),   32'(eh));
    endtask

    // Drive between edges, then check just after the capturing edge.
    task automatic step(input string tag, input logic [7:0] xv, input logic ev);
        int   ey;
        logic ei;
        @(negedge clk);
        bus.x   = xv;
        bus.ena = ev;
        @(posedge clk);
        #1;
        ey = model_y(xv, ev);
        ei = ev && (xv != 8'd0);
        check_out(tag, ey, ei, model_h(ei, ey));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.x    = 8'hFF;
        bus.ena  = 1'b1;

        // Reset holds outputs blank regardless of clock and inputs.
        #3;
        check_out("rst_imm", 0, 1'b0, 7'h7F);
        repeat (3) @(posedge clk);
        #1;
        check_out("rst_hold", 0, 1'b0, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst_rel", 7, 1'b1, model_h(1'b1, 7));

        for (int i = 0; i < 256; i++) step("dis", 8'(i), 1'b0);
        for (int i = 0; i < 256; i++) step("en", 8'(i), 1'b1);

        step("ex01", 8'h01, 1'b1);
        check("ex01.lit", 32'(bus.y), 32'd0);
        step("ex2c", 8'h2C, 1'b1);
        check("ex2c.lit", 32'(bus.y), 32'd5);
        step("exa6", 8'hA6, 1'b1);
        check("exa6.lit", 32'(bus.y), 32'd7);

        // Mid-cycle input change must not reach the outputs before the next edge.
        step("lat0", 8'h10, 1'b1);
        #2;
        bus.x = 8'h02;
        #1;
        check_out("lat_hold", 4, 1'b1, model_h(1'b1, 4));
        @(posedge clk);
        #1;
        check_out("lat_new", 1, 1'b1, model_h(1'b1, 1));

        step("tog1", 8'h44, 1'b1);
        step("tog0", 8'h44, 1'b0);
        step("tog1b", 8'h44, 1'b1);

        // Asynchronous reset between edges while y=6.
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst", 0, 1'b0, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        step("arst_rel", 8'h44, 1'b1);

        for (int i = 0; i < 300; i++) begin
            step("rnd", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
